dc_stream_engine: RTL and testbench
===================================

Name: dc_stream_engine

Overview:
- RAM-side data mover directly downstream of the data & control router top.
- Consumes the router's fft_enable/fir_enable/iir_enable; streams filesize input words from RAM at offset into the selected accelerator's input FIFO.
- Drains that accelerator's output FIFO back to RAM.
- Returns the per-accelerator read_done/write_done pair that the router's FSM waits on.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 32, RAM and FIFO data width.
- LEN_W, 16, width of filesize and the word counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fft_enable, fir_enable, iir_enable  in  1 each  accelerator select from router.
- offset  in  ADDR_W  base RAM address of input file.
- filesize  in  LEN_W  word count, input and output.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_read_enable.
- ram_read_enable, ram_write_enable  out  1 each  RAM strobes.
- address  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- to_fft_full, to_fir_full, to_iir_full  in  1 each  accelerator input FIFO full.
- from_fft_empty, from_fir_empty, from_iir_empty  in  1 each  accelerator output FIFO empty.
- fft_put_req, fir_put_req, iir_put_req  out  1 each  push strobe to input FIFO.
- fft_get_req, fir_get_req, iir_get_req  out  1 each  pop strobe from output FIFO.
- acc_data_in  out  DATA_W  shared push data, qualified by *_put_req.
- fft_data_out, fir_data_out, iir_data_out  in  DATA_W  pop data, valid 1 cycle after *_get_req.
- fft_read_done, fft_write_done, fir_read_done, fir_write_done, iir_read_done, iir_write_done  out  1 each  status to router.

Behaviour:
- Reset (async, reset=0): all outputs 0; state IDLE; rd_cnt=wr_cnt=0; latched base/len=0.
- Select: sel = fft if fft_enable, else fir if fir_enable, else iir if iir_enable (fixed priority); none → no select.
- IDLE: on any enable → LOAD.
- LOAD (1 cycle): latch sel, base=offset, len=filesize; clear counters and done flags → RUN.
- RUN: two-phase slot, ISSUE then COMPLETE; at most one operation per 2 cycles.
  - ISSUE, write eligible (wr_cnt<len and from_<sel>_empty=0): <sel>_get_req=1 for 1 cycle. Write has priority over read.
  - ISSUE, read eligible otherwise (rd_cnt<len and to_<sel>_full=0): ram_read_enable=1, address=base+rd_cnt.
  - ISSUE, nothing eligible: stay in ISSUE.
  - COMPLETE after get: ram_write_enable=1, address=base+len+wr_cnt, ram_wdata=<sel>_data_out; wr_cnt++.
  - COMPLETE after read: <sel>_put_req=1, acc_data_in=ram_rdata; rd_cnt++.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).
- <sel>_read_done=1 from the cycle after rd_cnt reaches len; <sel>_write_done likewise for wr_cnt. Non-selected done outputs stay 0.
- Both counters equal len → DONE; hold both done flags high.
- DONE: when the selected enable deasserts → IDLE; done flags clear the same edge.
- filesize=0: LOAD→RUN, then DONE the next cycle; no RAM or FIFO strobes.
- Selected enable drops, or a higher-priority enable rises, while in RUN: abort next edge.
  - Any in-flight COMPLETE is suppressed (no write, no put).
  - Flags and counters clear; → IDLE, then restarts LOAD if an enable is still high.
- ram_read_enable and ram_write_enable are never high together; at most one *_put_req and one *_get_req high per cycle.

Optional Feature:
- Macro DC_STREAM_CHECKSUM_EN.
- Defined: extra output port checksum [DATA_W-1:0].
  - Cleared in LOAD; XOR-accumulates every ram_wdata word written.
  - Holds its value through DONE until the next LOAD; 0 at reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-RUN (fft, len=8, rd_cnt=3) → all outputs 0 asynchronously; IDLE after release.
- fft_enable=1, offset=0x0100, filesize=4, FIFOs never full, output FIFO returns after 4 puts:
  - reads at 0x0100..0x0103; writes at 0x0104..0x0107.
  - fft_read_done then fft_write_done high.
  - Drop enable → both 0 on the next cycle.
- fir selected, to_fir_full=1 and from_fir_empty=0 simultaneously → get/write issued every ISSUE slot; no reads until full deasserts; no deadlock.
- iir, filesize=0 → iir_read_done=iir_write_done=1 two cycles after LOAD; zero RAM strobes.
- offset=0xFFFE, filesize=3 → read addresses 0xFFFE, 0xFFFF, 0x0000; write addresses 0x0001..0x0003.
- With DC_STREAM_CHECKSUM_EN: output words 0x1, 0x2, 0x4 → checksum=0x7. fft_enable and fir_enable both high → only fft strobes.

Source files
------------

// File: rtl/dc_stream_engine.sv
// RAM-side data mover: streams a file from RAM into the selected accelerator and drains its
// results back to RAM just past the input file. Optional checksum port: DC_STREAM_CHECKSUM_EN.
module dc_stream_engine #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fft_enable,
  input  logic              fir_enable,
  input  logic              iir_enable,
  input  logic [ADDR_W-1:0] offset,
  input  logic [LEN_W-1:0]  filesize,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              to_fft_full,
  input  logic              to_fir_full,
  input  logic              to_iir_full,
  input  logic              from_fft_empty,
  input  logic              from_fir_empty,
  input  logic              from_iir_empty,
  output logic              fft_put_req,
  output logic              fir_put_req,
  output logic              iir_put_req,
  output logic              fft_get_req,
  output logic              fir_get_req,
  output logic              iir_get_req,
  output logic [DATA_W-1:0] acc_data_in,
  input  logic [DATA_W-1:0] fft_data_out,
  input  logic [DATA_W-1:0] fir_data_out,
  input  logic [DATA_W-1:0] iir_data_out,
  output logic              fft_read_done,
  output logic              fft_write_done,
  output logic              fir_read_done,
  output logic              fir_write_done,
  output logic              iir_read_done,
  output logic              iir_write_done
`ifdef DC_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StGet, StRead, StDone} state_e;
  typedef enum logic [1:0] {SelNone, SelFft, SelFir, SelIir} sel_e;

  state_e            state_q, state_d;
  sel_e              sel_q, sel_d, sel_now;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic [DATA_W-1:0] csum_q, csum_d;

  logic              sel_en, sel_full, sel_empty, higher_en, abort, in_run;
  logic              rd_left, wr_left, get_any, put_any;
  logic [DATA_W-1:0] sel_dout;

  always_comb begin
    sel_now = SelNone;
    if (fft_enable)      sel_now = SelFft;
    else if (fir_enable) sel_now = SelFir;
    else if (iir_enable) sel_now = SelIir;
  end

  always_comb begin
    sel_en    = 1'b0;
    sel_full  = 1'b1;
    sel_empty = 1'b1;
    sel_dout  = '0;
    higher_en = 1'b0;
    case (sel_q)
      SelFft: begin
        sel_en = fft_enable; sel_full = to_fft_full; sel_empty = from_fft_empty;
        sel_dout = fft_data_out;
      end
      SelFir: begin
        sel_en = fir_enable; sel_full = to_fir_full; sel_empty = from_fir_empty;
        sel_dout = fir_data_out; higher_en = fft_enable;
      end
      SelIir: begin
        sel_en = iir_enable; sel_full = to_iir_full; sel_empty = from_iir_empty;
        sel_dout = iir_data_out; higher_en = fft_enable | fir_enable;
      end
      default: ;
    endcase
  end

  assign in_run  = (state_q == StIssue) || (state_q == StGet) || (state_q == StRead);
  assign abort   = in_run && (!sel_en || higher_en);
  assign rd_left = (rd_cnt_q != len_q);
  assign wr_left = (wr_cnt_q != len_q);

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    base_d           = base_q;
    len_d            = len_q;
    rd_cnt_d         = rd_cnt_q;
    wr_cnt_d         = wr_cnt_q;
    rd_done_d        = rd_done_q;
    wr_done_d        = wr_done_q;
    csum_d           = csum_q;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    address          = '0;
    ram_wdata        = '0;
    acc_data_in      = '0;
    get_any          = 1'b0;
    put_any          = 1'b0;

    if (abort) begin
      // Any in-flight completion is dropped; the next transfer starts from scratch.
      state_d   = StIdle;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
    end else begin
      if (in_run) begin
        if (!rd_left) rd_done_d = 1'b1;
        if (!wr_left) wr_done_d = 1'b1;
      end
      case (state_q)
        StIdle: if (sel_now != SelNone) state_d = StLoad;
        StLoad: begin
          sel_d     = sel_now;
          base_d    = offset;
          len_d     = filesize;
          rd_cnt_d  = '0;
          wr_cnt_d  = '0;
          rd_done_d = 1'b0;
          wr_done_d = 1'b0;
          csum_d    = '0;
          state_d   = StIssue;
        end
        StIssue: begin
          if (!rd_left && !wr_left) begin
            state_d = StDone;
          end else if (wr_left && !sel_empty) begin
            get_any = 1'b1;
            state_d = StGet;
          end else if (rd_left && !sel_full) begin
            ram_read_enable = 1'b1;
            address         = base_q + ADDR_W'(rd_cnt_q);
            state_d         = StRead;
          end
        end
        StGet: begin
          ram_write_enable = 1'b1;
          address          = base_q + ADDR_W'(len_q) + ADDR_W'(wr_cnt_q);
          ram_wdata        = sel_dout;
          csum_d           = csum_q ^ sel_dout;
          wr_cnt_d         = wr_cnt_q + LEN_W'(1);
          state_d          = StIssue;
        end
        StRead: begin
          put_any     = 1'b1;
          acc_data_in = ram_rdata;
          rd_cnt_d    = rd_cnt_q + LEN_W'(1);
          state_d     = StIssue;
        end
        StDone: begin
          if (!sel_en) begin
            state_d   = StIdle;
            rd_done_d = 1'b0;
            wr_done_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sel_q     <= SelNone;
      base_q    <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      base_q    <= base_d;
      len_q     <= len_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      csum_q    <= csum_d;
    end
  end

  assign fft_put_req    = put_any && (sel_q == SelFft);
  assign fir_put_req    = put_any && (sel_q == SelFir);
  assign iir_put_req    = put_any && (sel_q == SelIir);
  assign fft_get_req    = get_any && (sel_q == SelFft);
  assign fir_get_req    = get_any && (sel_q == SelFir);
  assign iir_get_req    = get_any && (sel_q == SelIir);
  assign fft_read_done  = rd_done_q && (sel_q == SelFft);
  assign fir_read_done  = rd_done_q && (sel_q == SelFir);
  assign iir_read_done  = rd_done_q && (sel_q == SelIir);
  assign fft_write_done = wr_done_q && (sel_q == SelFft);
  assign fir_write_done = wr_done_q && (sel_q == SelFir);
  assign iir_write_done = wr_done_q && (sel_q == SelIir);

`ifdef DC_STREAM_CHECKSUM_EN
  assign checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_dc_stream_engine.sv
// Bench for dc_stream_engine: RAM and accelerator FIFO models plus transfer-level expectations.
// Build with DC_STREAM_CHECKSUM_EN defined to also exercise the checksum port.
module tb_dc_stream_engine;

  typedef logic [31:0] word_q_t [$];
  localparam logic [31:0] Xform = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  en = '0;
  logic [15:0] offset = '0;
  logic [15:0] filesize = '0;
  logic [31:0] ram_rdata = '0;
  logic        ram_read_enable, ram_write_enable;
  logic [15:0] address;
  logic [31:0] ram_wdata, acc_data_in;
  logic [2:0]  full_r = '0;
  logic [2:0]  empty_r = '1;
  logic [2:0]  put, get, rd_done, wr_done;
  logic [31:0] dout_r [3];
`ifdef DC_STREAM_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] mem [logic [15:0]];
  word_q_t     in_q [3];
  word_q_t     out_q [3];
  logic [15:0] rd_addrs [$];
  logic [15:0] wr_addrs [$];
  int          put_cnt [3];
  int          get_cnt [3];
  int          viol = 0;
  logic [2:0]  force_full = '0;
  bit          rand_full = 1'b0;
  bit          gen_on_put = 1'b1;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dc_stream_engine dut (
    .clk(clk), .reset(reset),
    .fft_enable(en[0]), .fir_enable(en[1]), .iir_enable(en[2]),
    .offset(offset), .filesize(filesize), .ram_rdata(ram_rdata),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .address(address), .ram_wdata(ram_wdata),
    .to_fft_full(full_r[0]), .to_fir_full(full_r[1]), .to_iir_full(full_r[2]),
    .from_fft_empty(empty_r[0]), .from_fir_empty(empty_r[1]), .from_iir_empty(empty_r[2]),
    .fft_put_req(put[0]), .fir_put_req(put[1]), .iir_put_req(put[2]),
    .fft_get_req(get[0]), .fir_get_req(get[1]), .iir_get_req(get[2]),
    .acc_data_in(acc_data_in),
    .fft_data_out(dout_r[0]), .fir_data_out(dout_r[1]), .iir_data_out(dout_r[2]),
    .fft_read_done(rd_done[0]), .fft_write_done(wr_done[0]),
    .fir_read_done(rd_done[1]), .fir_write_done(wr_done[1]),
    .iir_read_done(rd_done[2]), .iir_write_done(wr_done[2])
`ifdef DC_STREAM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : {~a, a ^ 16'h1234};
  endfunction

  // RAM and FIFO models: internal bookkeeping is immediate, DUT-visible signals use <=.
  always @(posedge clk) begin
    if (ram_read_enable) ram_rdata <= mem_rd(address);
    if (ram_write_enable) mem[address] = ram_wdata;
    for (int a = 0; a < 3; a++) begin
      if (put[a]) begin
        in_q[a].push_back(acc_data_in);
        if (gen_on_put) out_q[a].push_back(acc_data_in ^ Xform);
      end
      if (get[a] && out_q[a].size() > 0) dout_r[a] <= out_q[a].pop_front();
      empty_r[a] <= (out_q[a].size() == 0);
      full_r[a]  <= force_full[a] | (rand_full && ($urandom_range(0, 2) == 0));
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (ram_read_enable) rd_addrs.push_back(address);
      if (ram_write_enable) wr_addrs.push_back(address);
      if (ram_read_enable && ram_write_enable) viol++;
      if ($countones(put) > 1 || $countones(get) > 1) viol++;
      for (int a = 0; a < 3; a++) begin
        if (put[a]) put_cnt[a]++;
        if (get[a]) get_cnt[a]++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int a = 0; a < 3; a++) begin
      in_q[a].delete();
      out_q[a].delete();
      put_cnt[a] = 0;
      get_cnt[a] = 0;
    end
    rd_addrs.delete();
    wr_addrs.delete();
    force_full = '0;
    rand_full  = 1'b0;
    gen_on_put = 1'b1;
  endtask

  function automatic logic [115:0] all_outputs();
    return {ram_read_enable, ram_write_enable, address, ram_wdata, acc_data_in,
            put, get, rd_done, wr_done};
  endfunction

  // One complete transfer against the address/data rules of the engine.
  task automatic run_txn(input int acc, input logic [15:0] base, input logic [15:0] len,
                         input bit rnd, input logic [2:0] extra);
    word_q_t     exp_in;
    logic [15:0] a;
    clear_models();
    rand_full = rnd;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      exp_in.push_back(mem_rd(a));
    end
    offset   = base;
    filesize = len;
    en       = extra | (3'b001 << acc);
    for (int c = 0; c < 4000 && !rd_done[acc]; c++) @(negedge clk);
    check("read_done_seen", rd_done[acc], 1'b1);
    if (len != 0) check("write_done_after_read", wr_done[acc], 1'b0);
    for (int c = 0; c < 4000 && !wr_done[acc]; c++) @(negedge clk);
    check("write_done_seen", wr_done[acc], 1'b1);
    check("read_done_held", rd_done[acc], 1'b1);
    check("read_count", rd_addrs.size(), len);
    check("write_count", wr_addrs.size(), len);
    check("put_words", in_q[acc].size(), len);
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      if (i < rd_addrs.size()) check("read_addr", rd_addrs[i], a);
      if (i < in_q[acc].size()) check("put_data", in_q[acc][i], exp_in[i]);
      a = base + len + 16'(i);
      if (i < wr_addrs.size()) check("write_addr", wr_addrs[i], a);
      check("write_data", mem_rd(a), exp_in[i] ^ Xform);
    end
    for (int b = 0; b < 3; b++) begin
      if (b != acc) begin
        check("other_strobes", put_cnt[b] + get_cnt[b], 0);
        check("other_done", {rd_done[b], wr_done[b]}, 2'b00);
      end
    end
    en = '0;
    @(negedge clk);
    check("done_cleared", {rd_done[acc], wr_done[acc]}, 2'b00);
    @(negedge clk);
  endtask

  initial begin
    int          acc;
    int          n_rd;
    logic [15:0] base;
    clear_models();
    #2;
    check("reset_outputs", all_outputs(), '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outputs(), '0);

    // Asynchronous reset in the middle of a transfer, after three words were pushed.
    offset = 16'h2000; filesize = 16'd8; en = 3'b001;
    for (int c = 0; c < 200 && put_cnt[0] < 3; c++) @(negedge clk);
    check("three_puts_before_reset", put_cnt[0], 3);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), '0);
    en = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", all_outputs(), '0);

    // Directed transfers, including the address wrap case.
    run_txn(0, 16'h0100, 16'd4, 1'b0, 3'b000);
    run_txn(0, 16'hFFFE, 16'd3, 1'b0, 3'b000);
    run_txn(0, 16'h0400, 16'd5, 1'b0, 3'b010);

    // fir: input side full, output side already holding results.
    clear_models();
    gen_on_put = 1'b0;
    force_full = 3'b010;
    for (int i = 0; i < 4; i++) out_q[1].push_back(32'hF00D_0000 + 32'(i));
    @(negedge clk);
    offset = 16'h0800; filesize = 16'd4; en = 3'b010;
    repeat (24) @(negedge clk);
    check("fir_full_no_reads", rd_addrs.size(), 0);
    check("fir_full_writes", wr_addrs.size(), 4);
    check("fir_write_done_early", wr_done[1], 1'b1);
    check("fir_read_done_early", rd_done[1], 1'b0);
    for (int i = 0; i < 4 && i < wr_addrs.size(); i++) begin
      check("fir_write_addr", wr_addrs[i], 16'h0804 + 16'(i));
      check("fir_write_data", mem_rd(16'h0804 + 16'(i)), 32'hF00D_0000 + 32'(i));
    end
    force_full = '0;
    for (int c = 0; c < 200 && !rd_done[1]; c++) @(negedge clk);
    check("fir_read_done_late", rd_done[1], 1'b1);
    check("fir_reads", rd_addrs.size(), 4);
    en = '0;
    repeat (2) @(negedge clk);

    // iir with an empty file: done pair two cycles after LOAD, no strobes at all.
    clear_models();
    offset = 16'h3000; filesize = 16'd0; en = 3'b100;
    @(negedge clk);
    @(negedge clk);
    check("zero_len_not_yet_done", {rd_done[2], wr_done[2]}, 2'b00);
    @(negedge clk);
    check("zero_len_done", {rd_done[2], wr_done[2]}, 2'b11);
    check("zero_len_no_strobes",
          rd_addrs.size() + wr_addrs.size() + put_cnt[2] + get_cnt[2], 0);
    en = '0;
    @(negedge clk);
    check("zero_len_cleared", {rd_done[2], wr_done[2]}, 2'b00);
    @(negedge clk);

    // fir aborted by fft rising: nothing further may reach RAM or fir.
    clear_models();
    offset = 16'h5000; filesize = 16'd8; en = 3'b010;
    for (int c = 0; c < 200 && put_cnt[1] < 2; c++) @(negedge clk);
    en = 3'b011;
    @(negedge clk);
    en = '0;
    n_rd = rd_addrs.size();
    check("abort_fir_done", {rd_done[1], wr_done[1]}, 2'b00);
    repeat (8) @(negedge clk);
    check("abort_no_more_reads", rd_addrs.size(), n_rd);
    check("abort_no_fft", put_cnt[0] + get_cnt[0], 0);
    check("abort_idle", all_outputs(), '0);

`ifdef DC_STREAM_CHECKSUM_EN
    clear_models();
    gen_on_put = 1'b0;
    out_q[0].push_back(32'h1); out_q[0].push_back(32'h2); out_q[0].push_back(32'h4);
    @(negedge clk);
    offset = 16'h6000; filesize = 16'd3; en = 3'b001;
    for (int c = 0; c < 200 && !(rd_done[0] && wr_done[0]); c++) @(negedge clk);
    check("csum_done", {rd_done[0], wr_done[0]}, 2'b11);
    check("csum_value", checksum, 32'h7);
    en = '0;
    repeat (2) @(negedge clk);
    check("csum_held", checksum, 32'h7);
`endif

    // Randomized transfers with a randomly stalling input FIFO.
    for (int t = 0; t < 8; t++) begin
      acc  = $urandom_range(0, 2);
      base = 16'($urandom);
      run_txn(acc, base, 16'($urandom_range(1, 10)), 1'b1, 3'b000);
    end

    check("strobe_exclusivity", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
